// File: rtl/fp_cvt_s_w.sv
// fp_cvt_s_w: int32/uint32 to IEEE-754 binary32, three compute stages.
// Define FP_CVT_RM_EN to add the a_tuser rounding-mode input.
module fp_cvt_s_w #(
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] a_tdata,
  input  logic        a_tvalid,
`ifdef FP_CVT_RM_EN
  input  logic [2:0]  a_tuser,
`endif
  output logic        a_tready,
  output logic [31:0] r_tdata,
  output logic        r_tvalid,
  input  logic        r_tready
);

  logic        adv;
  logic [2:0]  a_rm;

`ifdef FP_CVT_RM_EN
  assign a_rm = a_tuser;
`else
  assign a_rm = 3'b000;
`endif

  logic        in_v_q, in_v_d;
  logic [31:0] in_a_q, in_a_d;
  logic [2:0]  in_rm_q, in_rm_d;

  logic        s1_v_q, s1_v_d;
  logic        s1_sign_q, s1_sign_d;
  logic        s1_zero_q, s1_zero_d;
  logic [31:0] s1_mag_q, s1_mag_d;
  logic [2:0]  s1_rm_q, s1_rm_d;

  logic        s2_v_q, s2_v_d;
  logic        s2_sign_q, s2_sign_d;
  logic        s2_zero_q, s2_zero_d;
  logic [30:0] s2_frac_q, s2_frac_d;
  logic [7:0]  s2_exp_q, s2_exp_d;
  logic [2:0]  s2_rm_q, s2_rm_d;

  logic        r_v_q, r_v_d;
  logic [31:0] r_data_q, r_data_d;

  logic        sign_c;
  logic [31:0] mag_c;
  logic [4:0]  lz_c;
  logic [31:0] norm_c;
  logic [7:0]  exp_c;
  logic        grd, stk, rup;
  logic [23:0] mant_r;
  logic [7:0]  exp_r;
  logic [31:0] res_c;

  assign adv      = ~(r_v_q & ~r_tready);
  assign a_tready = adv;
  assign r_tdata  = r_data_q;
  assign r_tvalid = r_v_q;

  // S1: split captured operand into sign and magnitude
  always_comb begin
    sign_c = SIGNED_IN & in_a_q[31];
    mag_c  = sign_c ? (~in_a_q + 32'd1) : in_a_q;
  end

  // S2: leading-zero count, normalize, biased exponent
  always_comb begin
    lz_c = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (s1_mag_q[i]) lz_c = 5'(31 - i);
    end
    norm_c = s1_mag_q << lz_c;
    exp_c  = 8'd158 - {3'd0, lz_c};
  end

  // S3: round per mode, fold mantissa carry into exponent, pack
  always_comb begin
    grd = s2_frac_q[7];
    stk = |s2_frac_q[6:0];
    rup = grd & (stk | s2_frac_q[8]);
    case (s2_rm_q)
      3'b001:  rup = 1'b0;
      3'b010:  rup = s2_sign_q & (grd | stk);
      3'b011:  rup = ~s2_sign_q & (grd | stk);
      3'b100:  rup = grd;
      default: ;
    endcase
    mant_r = {1'b0, s2_frac_q[30:8]} + {23'd0, rup};
    exp_r  = s2_exp_q + {7'd0, mant_r[23]};
    res_c  = s2_zero_q ? 32'd0
                       : {s2_sign_q, exp_r, mant_r[22:0]};
  end

  // Pipeline advance: everything shifts together or holds together
  always_comb begin
    in_v_d    = in_v_q;
    in_a_d    = in_a_q;
    in_rm_d   = in_rm_q;
    s1_v_d    = s1_v_q;
    s1_sign_d = s1_sign_q;
    s1_zero_d = s1_zero_q;
    s1_mag_d  = s1_mag_q;
    s1_rm_d   = s1_rm_q;
    s2_v_d    = s2_v_q;
    s2_sign_d = s2_sign_q;
    s2_zero_d = s2_zero_q;
    s2_frac_d = s2_frac_q;
    s2_exp_d  = s2_exp_q;
    s2_rm_d   = s2_rm_q;
    r_v_d     = r_v_q;
    r_data_d  = r_data_q;
    if (adv) begin
      in_v_d    = a_tvalid;
      in_a_d    = a_tdata;
      in_rm_d   = a_rm;
      s1_v_d    = in_v_q;
      s1_sign_d = sign_c;
      s1_zero_d = (mag_c == 32'd0);
      s1_mag_d  = mag_c;
      s1_rm_d   = in_rm_q;
      s2_v_d    = s1_v_q;
      s2_sign_d = s1_sign_q;
      s2_zero_d = s1_zero_q;
      s2_frac_d = norm_c[30:0];
      s2_exp_d  = exp_c;
      s2_rm_d   = s1_rm_q;
      r_v_d     = s2_v_q;
      if (s2_v_q) r_data_d = res_c;
    end
  end

  // State registers; reset drops every in-flight operand
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      in_v_q   <= 1'b0;
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      r_v_q    <= 1'b0;
      r_data_q <= 32'd0;
    end else begin
      in_v_q   <= in_v_d;
      s1_v_q   <= s1_v_d;
      s2_v_q   <= s2_v_d;
      r_v_q    <= r_v_d;
      r_data_q <= r_data_d;
    end
    in_a_q    <= in_a_d;
    in_rm_q   <= in_rm_d;
    s1_sign_q <= s1_sign_d;
    s1_zero_q <= s1_zero_d;
    s1_mag_q  <= s1_mag_d;
    s1_rm_q   <= s1_rm_d;
    s2_sign_q <= s2_sign_d;
    s2_zero_q <= s2_zero_d;
    s2_frac_q <= s2_frac_d;
    s2_exp_q  <= s2_exp_d;
    s2_rm_q   <= s2_rm_d;
  end

endmodule

// File: tb/tb_fp_cvt_s_w.sv
// tb_fp_cvt_s_w: signed and unsigned converters driven in lockstep,
// checked against an arithmetic reference model.
module tb_fp_cvt_s_w;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] a_tdata = 32'd0;
  logic        a_tvalid = 1'b0;
  logic        r_tready = 1'b1;
  logic        a_tready, r_tvalid;
  logic [31:0] r_tdata;
  logic        u_a_tready, u_r_tvalid;
  logic [31:0] u_r_tdata;
`ifdef FP_CVT_RM_EN
  logic [2:0]  a_tuser = 3'd0;
`endif

  int checks = 0;
  int errors = 0;
  int cur_rm = 0;
  int n_out = 0;
  bit held = 1'b0;
  logic [31:0] held_d = 32'd0;
  logic [31:0] q_s[$];
  logic [31:0] q_u[$];

  always #5 CLK = ~CLK;

  fp_cvt_s_w #(.SIGNED_IN(1'b1)) u_dut (
    .CLK(CLK), .RST_N(RST_N),
    .a_tdata(a_tdata), .a_tvalid(a_tvalid),
`ifdef FP_CVT_RM_EN
    .a_tuser(a_tuser),
`endif
    .a_tready(a_tready),
    .r_tdata(r_tdata), .r_tvalid(r_tvalid),
    .r_tready(r_tready)
  );

  fp_cvt_s_w #(.SIGNED_IN(1'b0)) u_dut_u (
    .CLK(CLK), .RST_N(RST_N),
    .a_tdata(a_tdata), .a_tvalid(a_tvalid),
`ifdef FP_CVT_RM_EN
    .a_tuser(a_tuser),
`endif
    .a_tready(u_a_tready),
    .r_tdata(u_r_tdata), .r_tvalid(u_r_tvalid),
    .r_tready(r_tready)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Value = q * d + r, with q holding 24 significant bits
  function automatic logic [31:0] ref_cvt(input logic [31:0] a,
                                          input bit sgn, input int rm);
    longint v, m, q, r, d;
    int e;
    bit s, up;
    v = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    if (v == 0) return 32'd0;
    s = (v < 0);
    m = s ? -v : v;
    e = 0;
    while ((longint'(1) << (e + 1)) <= m) e++;
    if (e <= 23) begin
      q = m << (23 - e);
      r = 0;
      d = 1;
    end else begin
      d = longint'(1) << (e - 23);
      q = m / d;
      r = m % d;
    end
    case (rm)
      1: up = 1'b0;
      2: up = s && (r != 0);
      3: up = !s && (r != 0);
      4: up = (2 * r >= d);
      default: up = (2 * r > d) || ((2 * r == d) && q[0]);
    endcase
    if (up) q++;
    if (q == (longint'(1) << 24)) begin
      q = longint'(1) << 23;
      e++;
    end
    return {s, 8'(e + 127), q[22:0]};
  endfunction

  task automatic set_rm(input int rm);
    cur_rm = rm;
`ifdef FP_CVT_RM_EN
    a_tuser = 3'(rm);
`endif
  endtask

  task automatic send_one(input string tag, input logic [31:0] a,
                          input int rm, input logic [31:0] exp_s,
                          input logic [31:0] exp_u);
    int lat;
    @(negedge CLK);
    a_tvalid = 1'b1;
    a_tdata  = a;
    r_tready = 1'b1;
    set_rm(rm);
    #1;
    chk({tag, "_rdy"}, {31'd0, a_tready}, 32'd1);
    @(negedge CLK);
    a_tvalid = 1'b0;
    lat = 0;
    while (!r_tvalid && lat < 8) begin
      @(negedge CLK);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_s"}, r_tdata, exp_s);
    chk({tag, "_u"}, u_r_tdata, exp_u);
    @(negedge CLK);
    chk({tag, "_pulse"}, {31'd0, r_tvalid}, 32'd0);
  endtask

  task automatic step(input logic v, input logic [31:0] d, input int rm,
                      input logic rr, output bit acc);
    @(negedge CLK);
    if (held) begin
      chk("hold_v", {31'd0, r_tvalid}, 32'd1);
      chk("hold_d", r_tdata, held_d);
    end
    a_tvalid = v;
    a_tdata  = d;
    r_tready = rr;
    set_rm(rm);
    #1;
    chk("ready", {31'd0, a_tready}, {31'd0, !(r_tvalid && !rr)});
    chk("ready_u", {31'd0, u_a_tready}, {31'd0, a_tready});
    acc = v && a_tready;
    if (acc) begin
      q_s.push_back(ref_cvt(d, 1'b1, rm));
      q_u.push_back(ref_cvt(d, 1'b0, rm));
    end
    if (r_tvalid && rr) begin
      n_out++;
      if (q_s.size() == 0) begin
        chk("spurious", {31'd0, r_tvalid}, 32'd0);
      end else begin
        chk("stream_s", r_tdata, q_s.pop_front());
        chk("stream_uv", {31'd0, u_r_tvalid}, 32'd1);
        chk("stream_u", u_r_tdata, q_u.pop_front());
      end
    end
    held   = r_tvalid && !rr;
    held_d = r_tdata;
  endtask

  function automatic logic [31:0] rnd_val();
    logic [31:0] x;
    case ($urandom_range(0, 4))
      0: x = $urandom;
      1: x = $urandom_range(0, 32'hFFFFFF);
      2: x = -$urandom_range(0, 32'hFFFFFF);
      3: x = (32'd1 << $urandom_range(0, 31)) + $urandom_range(0, 3) - 2;
      default: x = {$urandom_range(0, 1) == 1, 31'h7FFFFF80}
                   | $urandom_range(0, 255);
    endcase
    return x;
  endfunction

  initial begin
    logic [31:0] bp_vals [5];
    bit acc;
    int idx;
    bp_vals[0] = 32'd100;
    bp_vals[1] = -32'sd5;
    bp_vals[2] = 32'd16777217;
    bp_vals[3] = 32'h7FFFFFFF;
    bp_vals[4] = 32'h12345678;

    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_valid", {31'd0, r_tvalid}, 32'd0);
    chk("rst_data", r_tdata, 32'd0);
    RST_N = 1'b1;
    #1;
    chk("rst_ready", {31'd0, a_tready}, 32'd1);

    send_one("one", 32'h00000001, 0, 32'h3F800000, 32'h3F800000);
    send_one("m1", 32'hFFFFFFFF, 0, 32'hBF800000, 32'h4F800000);
    send_one("zero", 32'h00000000, 0, 32'h00000000, 32'h00000000);
    send_one("min", 32'h80000000, 0, 32'hCF000000, 32'h4F000000);
    send_one("tie_dn", 32'd16777217, 0, 32'h4B800000, 32'h4B800000);
    send_one("tie_up", 32'd16777219, 0, 32'h4B800002, 32'h4B800002);
    send_one("carry", 32'h7FFFFFFF, 0, 32'h4F000000, 32'h4F000000);

`ifdef FP_CVT_RM_EN
    send_one("rtz", 32'd16777219, 1, 32'h4B800001, 32'h4B800001);
    send_one("rup", 32'd16777219, 3, 32'h4B800002, 32'h4B800002);
    send_one("rmm", 32'd16777219, 4, 32'h4B800002, 32'h4B800002);
    send_one("rdn", -32'sd16777219, 2, 32'hCB800002,
             ref_cvt(-32'sd16777219, 1'b0, 2));
    set_rm(0);
`endif

    held  = 1'b0;
    n_out = 0;
    idx   = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      step(idx < 5, (idx < 5) ? bp_vals[idx] : 32'd0, 0,
           !(cyc >= 4 && cyc < 8), acc);
      if (cyc >= 4 && cyc < 8)
        chk("bp_stall_rdy", {31'd0, a_tready}, 32'd0);
      if (acc) idx++;
    end
    chk("bp_count", 32'(n_out), 32'd5);
    chk("bp_left", 32'(q_s.size()), 32'd0);

    held = 1'b0;
    for (int k = 0; k < 3; k++)
      step(1'b1, bp_vals[k], 0, 1'b1, acc);
    @(negedge CLK);
    a_tvalid = 1'b0;
    RST_N    = 1'b0;
    @(negedge CLK);
    chk("mid_rst_v", {31'd0, r_tvalid}, 32'd0);
    chk("mid_rst_d", r_tdata, 32'd0);
    RST_N = 1'b1;
    q_s.delete();
    q_u.delete();
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      chk("no_stale", {31'd0, r_tvalid | u_r_tvalid}, 32'd0);
    end
    send_one("fresh", 32'd2, 0, 32'h40000000, 32'h40000000);

    held  = 1'b0;
    n_out = 0;
    for (int k = 0; k < 400; k++) begin
`ifdef FP_CVT_RM_EN
      step($urandom_range(0, 3) != 0, rnd_val(), $urandom_range(0, 7),
           $urandom_range(0, 3) != 0, acc);
`else
      step($urandom_range(0, 3) != 0, rnd_val(), 0,
           $urandom_range(0, 3) != 0, acc);
`endif
    end
    for (int k = 0; k < 20 && q_s.size() != 0; k++)
      step(1'b0, 32'd0, 0, 1'b1, acc);
    chk("drain", 32'(q_s.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_cvt_s_w.md
Name: fp_cvt_s_w

Overview:
- Integer-to-single-precision converter serving FCVT.S.W (and FCVT.S.WU when unsigned).
- Sits directly downstream of the core FPU dispatcher on its fcvtsw AXI-stream port pair, as a native replacement for the vendor conversion core.
- 3-stage pipeline with full-pipeline backpressure and a held result register; IEEE-754 binary32 output.

Parameters:
- SIGNED_IN, 1: 1 = a_tdata is two's-complement int32 (FCVT.S.W); 0 = a_tdata is uint32 (FCVT.S.WU).

Ports:
- CLK  in  1  clock
- RST_N  in  1  reset; synchronous, active-low
- a_tdata  in  32  integer operand
- a_tvalid  in  1  operand valid
- a_tready  out  1  operand accept
- r_tdata  out  32  binary32 result
- r_tvalid  out  1  result valid
- r_tready  in  1  result accept

Behaviour:
- Reset values: r_tdata=0, r_tvalid=0, all internal stage valids=0. a_tready is combinational, so it reads 1 immediately after reset.
- adv = !(r_tvalid && !r_tready). When adv=1, every stage shifts one step; when adv=0, the whole pipeline and r_tdata/r_tvalid hold.
- a_tready = adv. An operand is accepted on an edge where a_tvalid && a_tready.
- Latency: an operand accepted at edge N makes r_tvalid=1 after edge N+3, provided there is no stall.
- Throughput: one result per cycle with no gaps while r_tready=1.
- r_tvalid/r_tdata stay stable while r_tvalid=1 and r_tready=0 (AXI-stream rule). A bubble entering the output sets r_tvalid=0 but leaves r_tdata unchanged.
- S1 (sign/magnitude):
  - sign = SIGNED_IN & a[31].
  - mag = sign ? -a : a, taken as an unsigned 32-bit value. 0x80000000 therefore gives mag=2^31.
  - zero flag = (mag==0).
- S2 (normalize):
  - lz = leading-zero count of mag (0..31; don't-care when zero).
  - norm = mag << lz, so bit31 = 1.
  - exp = 158 - lz.
- S3 (round/pack):
  - mant = norm[30:8]; guard = norm[7]; sticky = |norm[6:0].
  - RNE: round up when guard && (sticky || mant[0]).
  - Mantissa overflow on round-up (mant all ones): mant=0, exp+1.
  - zero → 0x00000000, never -0.
  - Result = {sign, exp[7:0], mant}.
  - Overflow to infinity is impossible (max exp 159).
- Exactness: every |value| < 2^24 converts exactly.
- Simultaneous events: a handshake on the input and the output in the same cycle is legal and both complete.
- Reset mid-operation: all in-flight operands are discarded and no result is emitted after reset. The dispatcher re-issues.
- Input with a_tvalid=0 while adv=1 inserts a bubble into S1.

Optional Feature:
- Macro: FP_CVT_RM_EN.
- When defined:
  - Adds input port a_tuser [2:0] carrying a RISC-V rounding mode, captured with a_tdata and carried down the pipeline.
  - Encodings: 000 RNE; 001 RTZ (never round up); 010 RDN (round up iff sign && (guard||sticky)); 011 RUP (round up iff !sign && (guard||sticky)); 100 RMM (round up iff guard).
  - Codes 101–111 behave as RNE.
  - Exponent carry rule is unchanged.
- When undefined: no a_tuser port; RNE only.

Test Plan:
- Basic values, SIGNED_IN=1, r_tready=1: a=0x00000001 → 0x3F800000; a=0xFFFFFFFF → 0xBF800000; a=0 → 0x00000000; a=0x80000000 → 0xCF000000. Each r_tvalid pulse appears exactly 3 cycles after acceptance.
- Rounding: 16777217 → 0x4B800000 (tie to even, down); 16777219 → 0x4B800002 (tie to even, up); 0x7FFFFFFF → 0x4F000000 (mantissa carry into exponent).
- Unsigned build, SIGNED_IN=0: a=0xFFFFFFFF → 0x4F800000; a=0x80000000 → 0x4F000000.
- Backpressure:
  - Stream 5 back-to-back operands and hold r_tready=0 from cycle 4 for 4 cycles.
  - Required: a_tready=0 during the stall; r_tdata stable; no operand lost or duplicated; results in order once r_tready=1.
- Reset mid-stream: assert RST_N=0 for 1 cycle with 3 operands in flight → r_tvalid=0 and r_tdata=0 after the edge; no stale results appear afterwards; a fresh a=2 → 0x40000000.
- FP_CVT_RM_EN, a=16777219:
  - RTZ → 0x4B800001
  - RUP → 0x4B800002
  - RMM → 0x4B800002
  - RDN with a=-16777219 → 0xCB800002
